// File: rtl/rand_gen_pkg.sv
// Shared types and helpers for the bounded pseudo-random draw block:
// FSM state encoding, Galois tap table and the power-of-two cover mask.
package rand_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    // Right-shift Galois masks giving period 2^width-1.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

    // Smallest 2^k-1 that is >= limit.
    function automatic logic [15:0] cover_mask(input logic [15:0] limit);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (m < limit) m = {m[14:0], 1'b1};
        end
        return m;
    endfunction

endpackage

// File: rtl/rand_gen_lfsr_core.sv
// Free-running Galois LFSR with seed load; a zero load value is swapped
// for SEED so the register can never lock up at zero.
module lfsr_core
    import rand_gen_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_state
);

    localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_advance;
    logic [WIDTH-1:0] w_load_val;

    assign w_advance  = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
    assign w_load_val = (i_load_val == '0) ? SEED : i_load_val;

    // A load takes precedence over the advance in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)         r_lfsr <= SEED;
        else if (i_load) r_lfsr <= w_load_val;
        else             r_lfsr <= w_advance;
    end

    assign o_state = r_lfsr;

endmodule

// File: rtl/rand_gen.sv
// Bounded uniform draw over [0, limit] by rejection sampling with a fallback
// after MAX_TRIES tries. Define RAND_GEN_NO_REPEAT_EN to also reject repeats.
module rand_gen
    import rand_gen_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SEED      = 8'hA5,
    parameter int               MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_seed_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_rand_out,
    output state_t           o_dbg_state,
    output logic [WIDTH-1:0] o_dbg_lfsr
);

    localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_tries;
    logic [WIDTH-1:0] r_lim_q;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_rand_out;
    logic             r_valid;
    logic [WIDTH-1:0] w_lfsr;
    logic [WIDTH-1:0] w_cand;
    logic             w_accept;
    logic             w_fallback;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (i_seed_load),
        .i_load_val (i_seed),
        .o_state    (w_lfsr)
    );

    assign w_cand = w_lfsr & r_mask;

`ifdef RAND_GEN_NO_REPEAT_EN
    // With a zero bound the only legal value is 0, so repeats must be allowed.
    assign w_accept = (w_cand <= r_lim_q) && ((w_cand != r_rand_out) || (r_lim_q == '0));
`else
    assign w_accept = (w_cand <= r_lim_q);
`endif

    assign w_fallback = !w_accept && (r_tries == LAST_TRY);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_req) w_state_next = DRAW;
            DRAW:    if (w_accept || w_fallback) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == DRAW);
    end

    // cand>>1 on fallback stays inside the bound because mask < 2*lim_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tries    <= '0;
            r_lim_q    <= '0;
            r_mask     <= '0;
            r_rand_out <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_lim_q <= i_limit;
                        r_mask  <= WIDTH'(cover_mask(16'(i_limit)));
                        r_tries <= '0;
                    end
                end
                DRAW: begin
                    if (w_accept) begin
                        r_rand_out <= w_cand;
                        r_valid    <= 1'b1;
                    end else if (w_fallback) begin
                        r_rand_out <= w_cand >> 1;
                        r_valid    <= 1'b1;
                    end else begin
                        r_tries <= r_tries + 4'd1;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign o_valid     = r_valid;
    assign o_rand_out  = r_rand_out;
    assign o_dbg_state = r_state;
    assign o_dbg_lfsr  = w_lfsr;

endmodule
